// File: rtl/is_rst_seq.sv
// is_rst_seq: reset sequencer. Synchronises N_SRC active-low reset requests,
// stretches them to a minimum assertion width and then releases N_OUT
// active-low domain resets one by one, STEP cycles apart.
module is_rst_seq #(
  parameter int N_SRC       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int N_OUT       = 3,
  parameter int STEP        = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] req_rstn_i,
  output logic [N_OUT-1:0] rstn_o,
  output logic             busy_o,
  output logic [N_SRC-1:0] cause_o
);

  localparam int CW = $clog2(MIN_ASSERT + 1);
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Synchroniser chain; vld_q marks stages that hold real samples rather
  // than the zeros loaded by rst_i, so those zeros never show up in cause_o.
  logic [N_SRC-1:0]       sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;

  logic [N_SRC-1:0] req_vec;
  logic             req_act;
  logic             req_vld;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    step_q, step_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] rstn_q, rstn_d;
  logic [N_OUT-1:0] rel_mask;
  logic             busy_q, busy_d;
  logic [N_SRC-1:0] cause_q, cause_d;

  // Shift each request through its own flop chain into the clk_i domain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      vld_q <= '0;
    end else begin
      sync_q[0] <= req_rstn_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_vec = ~sync_q[SYNC_STAGES-1];
  assign req_act = |req_vec;
  assign req_vld = vld_q[SYNC_STAGES-1];

  // Next-state, counters and output values of the sequencing FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    idx_d    = idx_q;
    rstn_d   = rstn_q;
    cause_d  = cause_q;
    rel_mask = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (IW'(i) == idx_q) rel_mask[i] = 1'b1;
    end

    case (state_q)
      ST_ASSERT: begin
        rstn_d = '0;
        if (req_vld) cause_d = cause_q | req_vec;
        if (req_act) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(MIN_ASSERT - 1)) begin
          state_d = ST_RELEASE;
          step_d  = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (req_act) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rstn_d  = '0;
          cause_d = req_vld ? req_vec : '0;
        end else if (step_q == SW'(STEP - 1)) begin
          rstn_d = rstn_q | rel_mask;
          step_d = '0;
          idx_d  = idx_q + IW'(1);
          if (idx_q == IW'(N_OUT - 1)) state_d = ST_RUN;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      ST_RUN: begin
        rstn_d = '1;
        if (req_act) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rstn_d  = '0;
          cause_d = req_vld ? req_vec : '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        rstn_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_RUN);
  end

  // State and output registers; rst_i re-asserts everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      busy_q  <= 1'b1;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign rstn_o  = rstn_q;
  assign busy_o  = busy_q;
  assign cause_o = cause_q;

endmodule

// File: doc/is_rst_seq.md
# is_rst_seq

Parametrised reset sequencer for the FPGA UART lab design. It synchronises N_SRC asynchronous active-low reset requests (button, watchdog, debug) into the clk_i domain and stretches any request to a minimum assertion width. It then releases N_OUT active-low domain resets one after another, STEP cycles apart, so that the clock/PLL, UART core and application logic leave reset in a fixed order. It sits at the top of the design and replaces the fixed 2-flop single-output reset synchroniser.

## Interface
Parameters:
- N_SRC, 2, number of asynchronous reset request inputs (≥1)
- SYNC_STAGES, 2, synchroniser depth per request (≥2)
- MIN_ASSERT, 16, minimum cycles all outputs stay asserted after the last request clears (≥1)
- N_OUT, 3, number of sequenced reset outputs (≥1)
- STEP, 4, cycles between successive channel releases (≥1)

Ports:
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  global reset; synchronous, active-high; one clock
- req_rstn_i  in  N_SRC  asynchronous active-low reset requests; bit i is synchronised independently
- rstn_o  out  N_OUT  sequenced active-low domain resets; bit 0 is released first
- busy_o  out  1  high while any rstn_o bit is low
- cause_o  out  N_SRC  sticky record of the sources that caused the current or last reset; 0 means rst_i only

## Operation
- Synchroniser: each request passes through its own SYNC_STAGES-flop chain. rst_i loads every stage with 0 (request active). req_act = OR of the inverted last stages.
- The FSM has three states: ASSERT, RELEASE and RUN.
- Counters: cnt is $clog2(MIN_ASSERT+1) bits wide, step_cnt is $clog2(STEP) bits wide (minimum 1), and idx is $clog2(N_OUT) bits wide (minimum 1).
- ASSERT: all rstn_o are 0.
  - If req_act, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - When cnt == MIN_ASSERT-1 and !req_act, go to RELEASE with step_cnt = 0 and idx = 0.
- RELEASE:
  - step_cnt increments each cycle.
  - When step_cnt == STEP-1: rstn_o[idx] <= 1, step_cnt <= 0, idx <= idx+1.
  - Releasing channel N_OUT-1 moves to RUN.
  - Released bits stay 1.
- RUN: all rstn_o are 1. Stay in RUN until req_act.
- A request seen in RELEASE or RUN (req_act = 1) causes, at the next edge:
  - all rstn_o <= 0,
  - state <= ASSERT, cnt <= 0,
  - cause_o <= the active request vector. This overwrites the old cause.
- In ASSERT, cause_o OR-accumulates the active request vector.
- busy_o is registered. It is 1 in ASSERT and RELEASE and 0 in RUN, and changes on the same edge as the state change.
- Reset values (rst_i): state ASSERT, cnt 0, step_cnt 0, idx 0, rstn_o all 0, busy_o 1, cause_o 0. rst_i takes priority over all other activity. rst_i during RELEASE or RUN re-asserts every output on the next edge.
- A request pulse must be low for at least one clk_i period plus setup time. Shorter pulses may be missed.

## Timing
- Edges are numbered from E0, the first rising edge at which rst_i = 0 is sampled, with all requests held high.
- req_act becomes 0 from E(SYNC_STAGES) onward.
- ASSERT→RELEASE happens at E(SYNC_STAGES+MIN_ASSERT-1).
- rstn_o[i] rises at E(SYNC_STAGES+MIN_ASSERT+(i+1)·STEP-1).
- busy_o falls with the release of rstn_o[N_OUT-1].
- Defaults: rstn_o[0] rises at E21, rstn_o[1] at E25, rstn_o[2] and busy_o↓ at E29.
- Request latency: req_rstn_i[k] is low before edge Ea, so stage 0 captures it at Ea. All rstn_o = 0 and busy_o = 1 after E(a+SYNC_STAGES).
- Release after a request clears follows the same schedule as after rst_i: SYNC_STAGES edges to clear the chain, then MIN_ASSERT, then STEP per channel.
- A request that reappears during ASSERT restarts cnt from 0. Stretching is measured from the last active cycle.
- Simultaneous requests from several sources set several cause_o bits in the same cycle.
- Outputs change only on clk_i edges. rstn_o is glitch-free because it comes straight from flops.

## Test plan
- Power-up: hold rst_i for 5 cycles with both requests high, then drop it. Required: rstn_o = 3'b000 through E20, 3'b001 at E21, 3'b011 at E25, 3'b111 and busy_o = 0 at E29, cause_o = 2'b00.
- Run-time request: in RUN, pull req_rstn_i[1] low for 3 cycles starting before Ea. Required: rstn_o = 0 after E(a+2), cause_o = 2'b10, and the full release sequence replays measured from the first edge at which the request is seen inactive.
- Re-trigger while stretching: pulse req_rstn_i[0] low at cnt = 10 in ASSERT. Required: cnt restarts, the release is delayed by the corresponding number of cycles, and cause_o gains bit 0.
- Request mid-RELEASE: assert req_rstn_i[0] after rstn_o = 3'b001. Required: rstn_o = 3'b000 SYNC_STAGES+1 edges later, cause_o = 2'b01, and the sequence restarts from channel 0.
- rst_i mid-RUN: assert rst_i for 1 cycle. Required: rstn_o = 0, busy_o = 1 and cause_o = 0 next edge, then the power-up schedule.
- Parameter sweep: N_OUT = 1, STEP = 1, MIN_ASSERT = 1, SYNC_STAGES = 3. Required: the single channel rises at E(3+1+1-1) = E4.
